rect_draw_engine: RTL
=====================

Name: rect_draw_engine

Overview:
Parametrised rectangle rasteriser for the VGA drawing path. It generalises the fixed 4x4 block and fixed-region clear into one engine. The engine accepts a start command with origin, runtime width/height, colour and mode (fill or outline). It emits one clipped pixel per handshake to the framebuffer writer, and sits between the game-sequence controller and the VGA adapter write port.

Parameters:
X_W, 9, bits of x coordinate
Y_W, 9, bits of y coordinate
SIZE_W, 9, bits of runtime width/height
COLOUR_W, 6, bits of colour
SCREEN_W, 320, pixels per row; x >= SCREEN_W is clipped
SCREEN_H, 240, rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  clock
resetn  in  1  reset
start  in  1  command strobe, sampled in IDLE only
x_in  in  X_W  origin x
y_in  in  Y_W  origin y
w_in  in  SIZE_W  width in pixels
h_in  in  SIZE_W  height in pixels
colour_in  in  COLOUR_W  draw colour (0 = black/clear)
mode_in  in  1  0 = fill, 1 = outline (1-pixel border)
busy  out  1  high from the cycle after an accepted start until the done pulse
done  out  1  one-cycle completion pulse
pix_valid  out  1  x/y/colour hold a pixel to write
pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready
x  out  X_W  pixel x
y  out  Y_W  pixel y
colour  out  COLOUR_W  pixel colour

Interface: reset resetn, synchronous, active-low; clock clk.

Behaviour:
- Reset values: state IDLE; busy, done and pix_valid are 0; x, y and colour are 0; internal counters are 0.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE + start:
  - Latch x0, y0, w, h, colour and mode; set col=0, row=0.
  - If w==0 or h==0, go to FIN with no pixels emitted.
  - Otherwise go to RUN.
- RUN: the candidate pixel is (x0+col, y0+row).
  - Sums are computed at X_W+1 / Y_W+1 bits.
  - Carry-out, or a sum >= SCREEN_W / SCREEN_H, means the pixel is clipped.
- Unclipped candidate:
  - Drive pix_valid=1 with x, y and colour registered.
  - Hold all three stable until pix_ready; advance the counters only on the handshake.
  - pix_valid may be 1 in the first RUN cycle.
- Clipped candidate: pix_valid=0 and the counters advance in that cycle (one cycle per skipped pixel, no stall).
- Raster order: col increments first. At col==w-1, col wraps to 0 and row increments.
- Outline mode:
  - On interior rows (0<row<h-1) with col==0, the next col is w-1 (interior skipped).
  - w==1 or h==1 degenerates to a plain line, with no duplicate pixels.
- Last pixel: the final counter advance (handshake or clip of col==w-1, row==h-1) moves the engine to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start in the done cycle is ignored; it is accepted the following cycle.
- start while busy is ignored; no queuing.
- pix_ready while pix_valid=0 has no effect.
- Reset mid-RUN: immediate return to IDLE, no done pulse, pix_valid drops.
- Latency:
  - First pixel: pix_valid asserts 1 cycle after start.
  - done asserts 1 cycle after the last handshake or clip.
  - Best case is 1 pixel per cycle with pix_ready held high.

Decomposition:
- Package draw_pkg:
  - state enum {IDLE, RUN, FIN};
  - MODE_FILL / MODE_OUTLINE constants;
  - default SCREEN_W/SCREEN_H and the colour width constant, shared with the VGA adapter and the sequence controller.
- Sub-module raster_counter (SIZE_W): col/row registers with an advance input, wrap, the outline interior skip, and a last flag.
- The top level holds the FSM, adders, clip compare and output registers.

Test Plan:
- Fill x=10, y=20, w=4, h=4, colour=6'h3F, pix_ready=1 -> 16 pixels, (10,20),(11,20)...(13,23) in raster order, on consecutive cycles; done 1 cycle after the 16th.
- Outline x=0, y=0, w=4, h=3 -> exactly 10 pixels, including (0,1) and (3,1), excluding (1,1) and (2,1); no duplicates.
- Clip x=318, y=238, w=4, h=4 on 320x240 -> only (318,238), (319,238), (318,239), (319,239) emitted; done after all 16 positions are consumed.
- Backpressure: fill 2x1 with pix_ready low for 5 cycles -> x/y/colour held at (x0,y0) for 5 cycles; second pixel only after the handshake.
- w=0 or h=0 -> no pix_valid, done pulse 1 cycle after start; start asserted during busy is ignored (pixel count unchanged).
- resetn low mid-fill (after pixel 5 of 16) -> next cycle busy=0, pix_valid=0, x=y=colour=0, no done; a new start then draws the full 16 pixels.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared drawing definitions for the VGA path: FSM states, draw modes and
// screen geometry used by the rasteriser, the VGA adapter and the sequencer.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int COLOUR_W_DEF = 6;

endpackage

// File: rtl/raster_counter.sv
// Column/row walker for a w x h rectangle in raster order. Exposes the
// next-cycle counter values so the owner can register pixel outputs one
// cycle ahead. In outline mode the interior of middle rows is skipped.
import draw_pkg::*;

module raster_counter #(
  parameter int SIZE_W = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  output logic [SIZE_W-1:0] col_nxt,
  output logic [SIZE_W-1:0] row_nxt,
  output logic              last
);

  localparam logic [SIZE_W-1:0] ONE = {{(SIZE_W-1){1'b0}}, 1'b1};

  logic [SIZE_W-1:0] col;
  logic [SIZE_W-1:0] row;
  logic [SIZE_W-1:0] w_m1;
  logic [SIZE_W-1:0] h_m1;
  logic              col_end;
  logic              row_end;
  logic              interior;

  // Next position: wrap at the row end first, then the outline skip, else step.
  always_comb begin
    w_m1     = w - ONE;
    h_m1     = h - ONE;
    col_end  = (col == w_m1);
    row_end  = (row == h_m1);
    last     = col_end && row_end;
    interior = (mode == MODE_OUTLINE) && (row != '0) && !row_end;
    col_nxt  = col;
    row_nxt  = row;
    if (load) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (advance) begin
      if (col_end) begin
        col_nxt = '0;
        row_nxt = row + ONE;
      end else if (interior && (col == '0)) begin
        col_nxt = w_m1;
      end else begin
        col_nxt = col + ONE;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: takes an origin, runtime size, colour and fill/outline
// mode, and emits one clipped pixel per valid/ready handshake. Pixel outputs
// are registered from the counter's next-cycle position so the first pixel is
// presented the cycle after start, and clipped positions cost one idle cycle.
import draw_pkg::*;

module rect_draw_engine #(
  parameter int X_W      = 9,
  parameter int Y_W      = 9,
  parameter int SIZE_W   = 9,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [SIZE_W-1:0]   w_in,
  input  logic [SIZE_W-1:0]   h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                mode_in,
  output logic                busy,
  output logic                done,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;
  localparam logic [X_W:0] SCR_W = XS'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = YS'(SCREEN_H);

  state_t            state;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [SIZE_W-1:0] w_r;
  logic [SIZE_W-1:0] h_r;
  logic              mode_r;

  logic              accept;
  logic              zero_size;
  logic              advance;
  logic [X_W-1:0]    x0_nxt;
  logic [Y_W-1:0]    y0_nxt;
  logic [SIZE_W-1:0] col_nxt;
  logic [SIZE_W-1:0] row_nxt;
  logic              last;
  logic [X_W:0]      sum_x;
  logic [Y_W:0]      sum_y;
  logic              clip_nxt;

  raster_counter #(
    .SIZE_W (SIZE_W)
  ) u_counter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .advance (advance),
    .mode    (mode_r),
    .w       (w_r),
    .h       (h_r),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (last)
  );

  // Command acceptance, counter advance and next-pixel address/clip.
  always_comb begin
    accept    = (state == IDLE) && start;
    zero_size = (w_in == '0) || (h_in == '0);
    // In RUN a low pix_valid means the current position was clipped.
    advance   = (state == RUN) && (!pix_valid || pix_ready);
    x0_nxt    = accept ? x_in : x0;
    y0_nxt    = accept ? y_in : y0;
    sum_x     = XS'(x0_nxt) + XS'(col_nxt);
    sum_y     = YS'(y0_nxt) + YS'(row_nxt);
    clip_nxt  = sum_x[X_W] || (sum_x >= SCR_W) || sum_y[Y_W] || (sum_y >= SCR_H);
  end

  // Control FSM with registered handshake, status and pixel outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      x0        <= '0;
      y0        <= '0;
      w_r       <= '0;
      h_r       <= '0;
      mode_r    <= MODE_FILL;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0     <= x_in;
            y0     <= y_in;
            w_r    <= w_in;
            h_r    <= h_in;
            mode_r <= mode_in;
            colour <= colour_in;
            if (zero_size) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              pix_valid <= !clip_nxt;
              x         <= sum_x[X_W-1:0];
              y         <= sum_y[Y_W-1:0];
            end
          end
        end
        RUN: begin
          if (advance) begin
            if (last) begin
              state     <= FIN;
              busy      <= 1'b0;
              done      <= 1'b1;
              pix_valid <= 1'b0;
            end else begin
              pix_valid <= !clip_nxt;
              x         <= sum_x[X_W-1:0];
              y         <= sum_y[Y_W-1:0];
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
